// File: rtl/osc_pkg.sv
// Shared types for the coupled oscillator neuron array.
package osc_pkg;

    typedef enum logic [0:0] {
        INTEG = 1'b0,
        REFR  = 1'b1
    } state_t;

    // Index width for an n-entry array; never collapses to zero bits.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/osc_neuron_cell.sv
// One oscillator neuron: phase counter, refractory countdown and registered spike.
module osc_neuron_cell
    import osc_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int REFRAC      = 2,
    parameter int COUPLE_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             inhibit,
    input  logic             coupled,
    input  logic [CNT_W-1:0] thresh,
    output logic             fire,
    output logic             spike
);

    localparam int RC_W = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;
    localparam logic [CNT_W:0] ONE  = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0] STEP = (CNT_W + 1)'(COUPLE_STEP);

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [RC_W-1:0]   rcnt;
    logic [CNT_W:0]    nxt;

    // One extra bit on nxt keeps the threshold compare exact at any CNT_W.
    always_comb begin
        nxt  = {1'b0, count} + ONE + (coupled ? STEP : '0);
        fire = enable && !inhibit && (thresh != '0) && (state == INTEG)
               && (nxt >= {1'b0, thresh});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            state <= INTEG;
            rcnt  <= '0;
            spike <= 1'b0;
        end else if (inhibit) begin
            count <= '0;
            state <= INTEG;
            rcnt  <= '0;
            spike <= 1'b0;
        end else if (!enable) begin
            spike <= 1'b0;
        end else if (state == REFR) begin
            count <= '0;
            spike <= 1'b0;
            if (rcnt <= RC_W'(1)) begin
                state <= INTEG;
                rcnt  <= '0;
            end else begin
                rcnt <= rcnt - RC_W'(1);
            end
        end else if (thresh == '0) begin
            count <= '0;
            spike <= 1'b0;
        end else if (fire) begin
            count <= '0;
            spike <= 1'b1;
            if (REFRAC != 0) begin
                state <= REFR;
                rcnt  <= RC_W'(REFRAC);
            end
        end else begin
            count <= nxt[CNT_W-1:0];
            spike <= 1'b0;
        end
    end

endmodule

// File: rtl/osc_neuron_array.sv
// Array of coupled oscillator neurons with per-channel thresholds and a sync flag.
module osc_neuron_array
    import osc_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int THRESH_RST  = 5,
    parameter int REFRAC      = 2,
    parameter int COUPLE_STEP = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_CH-1:0]           inhibit,
    input  logic                      cfg_we,
    input  logic [ch_w(N_CH)-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]          cfg_thresh,
    output logic [N_CH-1:0]           spike,
    output logic                      sync
);

    logic [N_CH-1:0][CNT_W-1:0] thresh;
    logic [N_CH-1:0]            fire;
    logic [N_CH-1:0]            coupled;
    logic [N_CH-1:0]            mask;

    // Cells sample the old threshold, so a same-edge write never affects that edge's decision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) thresh[i] <= CNT_W'(THRESH_RST);
        end else if (cfg_we && (int'(cfg_ch) < N_CH)) begin
            thresh[cfg_ch] <= cfg_thresh;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign coupled[i] = |(spike & ~(N_CH'(1) << i));
        assign mask[i]    = (thresh[i] != '0) && !inhibit[i];

        osc_neuron_cell #(
            .CNT_W      (CNT_W),
            .REFRAC     (REFRAC),
            .COUPLE_STEP(COUPLE_STEP)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .inhibit(inhibit[i]),
            .coupled(coupled[i]),
            .thresh (thresh[i]),
            .fire   (fire[i]),
            .spike  (spike[i])
        );
    end

    // Registered alongside the spikes so the flag lines up with the pulses it describes.
    always_ff @(posedge clk) begin
        if (!reset) sync <= 1'b0;
        else        sync <= enable && (mask != '0) && (fire == mask);
    end

endmodule

// File: tb/tb_osc_neuron_array.sv
// Directed bench for osc_neuron_array with a cycle model feeding an expectation queue.
module tb_osc_neuron_array;

    localparam int N = 4;
    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  inhibit = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = '0;
    logic [W-1:0]  cfg_thresh = '0;
    logic [N-1:0]  spike;
    logic          sync;

    osc_neuron_array #(
        .N_CH(N), .CNT_W(W), .THRESH_RST(5), .REFRAC(2), .COUPLE_STEP(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .inhibit(inhibit),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_thresh(cfg_thresh),
        .spike(spike), .sync(sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] sp;
        logic         sy;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           m_count[N];
    int           m_rcnt[N];
    int           m_thr[N];
    bit           m_refr[N];
    logic [N-1:0] m_spike = '0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour for one clock edge, evaluated from the inputs currently driven.
    task automatic model_push();
        logic [N-1:0] nsp;
        logic [N-1:0] msk;
        logic         cpl;
        int           nx;
        exp_t         e;
        for (int i = 0; i < N; i++) begin
            cpl    = |(m_spike & ~(4'b0001 << i));
            nsp[i] = 1'b0;
            msk[i] = (m_thr[i] != 0) && !inhibit[i];
            if (!reset) begin
                m_count[i] = 0; m_refr[i] = 0; m_rcnt[i] = 0;
            end else if (inhibit[i]) begin
                m_count[i] = 0; m_refr[i] = 0; m_rcnt[i] = 0;
            end else if (!enable) begin
            end else if (m_refr[i]) begin
                m_count[i] = 0;
                if (m_rcnt[i] == 1) m_refr[i] = 0;
                else m_rcnt[i]--;
            end else if (m_thr[i] == 0) begin
                m_count[i] = 0;
            end else begin
                nx = m_count[i] + 1 + (cpl ? 1 : 0);
                if (nx >= m_thr[i]) begin
                    nsp[i] = 1'b1; m_count[i] = 0; m_refr[i] = 1; m_rcnt[i] = 2;
                end else begin
                    m_count[i] = nx;
                end
            end
        end
        if (!reset) begin
            for (int i = 0; i < N; i++) m_thr[i] = 5;
        end else if (cfg_we) begin
            m_thr[cfg_ch] = int'(cfg_thresh);
        end
        m_spike = nsp;
        e.sp = nsp;
        e.sy = reset && enable && (msk != '0) && (nsp == msk);
        exp_q.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_spike"}, 8'(spike), 8'(e.sp));
        chk({tag, "_sync"}, 8'(sync), 8'(e.sy));
    endtask

    initial begin
        bit found;
        int sync_seen;
        for (int i = 0; i < N; i++) begin
            m_count[i] = 0; m_rcnt[i] = 0; m_thr[i] = 0; m_refr[i] = 0;
        end

        // Reset state
        step("rst");
        step("rst");
        chk("rst_spike0", 8'(spike), 8'h00);
        chk("rst_sync0", 8'(sync), 8'h00);

        // 1: all thresholds 5 -> spikes on edges 5, 12, 19 with sync
        reset = 1'b1;
        enable = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step("t1");
            chk("t1_edge_spike", 8'(spike), (e == 5 || e == 12 || e == 19) ? 8'h0F : 8'h00);
            chk("t1_edge_sync", 8'(sync), (e == 5 || e == 12 || e == 19) ? 8'h01 : 8'h00);
        end

        // 2: ch1 slowed to 8 and pulled by the other channels
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_thresh = 8'd8;
        step("t2_wr");
        cfg_we = 1'b0;
        for (int e = 0; e < 40; e++) step("t2");

        // 3: inhibit ch2 during its refractory window
        found = 1'b0;
        for (int e = 0; e < 30 && !found; e++) begin
            step("t3_seek");
            found = m_spike[2];
        end
        chk("t3_found", 8'(found), 8'h01);
        inhibit = 4'b0100;
        for (int e = 0; e < 3; e++) begin
            step("t3_inh");
            chk("t3_inh_quiet", 8'(spike[2]), 8'h00);
        end
        inhibit = '0;
        for (int e = 0; e < 12; e++) step("t3_rel");

        // 4: freeze at count 3, resume -> spike on the 2nd enabled edge
        reset = 1'b0;
        step("t4_rst");
        reset = 1'b1;
        for (int e = 0; e < 3; e++) step("t4_run");
        enable = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step("t4_frz");
            chk("t4_frz_quiet", 8'(spike), 8'h00);
        end
        enable = 1'b1;
        step("t4_re1");
        chk("t4_re1_spike", 8'(spike), 8'h00);
        step("t4_re2");
        chk("t4_re2_spike", 8'(spike), 8'h0F);

        // 5: lower ch0 threshold below its count, then switch it off
        reset = 1'b0; enable = 1'b0;
        step("t5_rst");
        reset = 1'b1;
        inhibit = 4'b1110;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_thresh = 8'd8;
        step("t5_wr8");
        cfg_we = 1'b0;
        enable = 1'b1;
        for (int e = 0; e < 4; e++) step("t5_cnt");
        cfg_we = 1'b1; cfg_thresh = 8'd2;
        step("t5_wr2");
        chk("t5_oldthr_nofire", 8'(spike[0]), 8'h00);
        cfg_we = 1'b0;
        step("t5_fire");
        chk("t5_fire_next", 8'(spike[0]), 8'h01);
        cfg_we = 1'b1; cfg_thresh = 8'd0;
        step("t5_wr0");
        cfg_we = 1'b0;
        inhibit = '0;
        sync_seen = 0;
        for (int e = 0; e < 30; e++) begin
            step("t5_off");
            chk("t5_off_quiet", 8'(spike[0]), 8'h00);
            if (sync) sync_seen++;
        end
        chk("t5_sync_seen", 8'(sync_seen > 0), 8'h01);

        // 6: reset during a spike with a pending write
        found = 1'b0;
        for (int e = 0; e < 20 && !found; e++) begin
            step("t6_seek");
            found = (m_spike != '0);
        end
        chk("t6_found", 8'(found), 8'h01);
        reset = 1'b0;
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_thresh = 8'd9;
        step("t6_rst");
        chk("t6_rst_spike", 8'(spike), 8'h00);
        chk("t6_rst_sync", 8'(sync), 8'h00);
        reset = 1'b1;
        cfg_we = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step("t6_run");
            chk("t6_thr_rst_spike", 8'(spike), (e == 5) ? 8'h0F : 8'h00);
        end
        chk("t6_thr_rst_sync", 8'(sync), 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
